// File: rtl/clk_pkg.sv
// Shared definitions for the audio clock-source sequencer: FSM states, mux
// select encodings, default timing and small elaboration helpers.
package clk_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MUTE      = 3'd1,
    GATE_PRE  = 3'd2,
    SETTLE    = 3'd3,
    GATE_POST = 3'd4,
    UNMUTE    = 3'd5
  } state_t;

  localparam logic [2:0] SEL_PLL_OUT2  = 3'd1;
  localparam logic [2:0] SEL_PLL_OUT3  = 3'd2;
  localparam logic [2:0] SEL_PLL_OUT4  = 3'd3;
  localparam logic [2:0] SEL_PLL_OUT5  = 3'd4;
  localparam logic [2:0] SEL_SUB_OUT1  = 3'd5;
  localparam logic [2:0] SEL_SUB_OUTD2 = 3'd6;
  localparam logic [2:0] SEL_SUB_OUTD4 = 3'd7;

  localparam int         DEF_MUTE_CYCLES   = 256;
  localparam int         DEF_GATE_CYCLES   = 16;
  localparam int         DEF_SETTLE_CYCLES = 64;
  localparam int         DEF_LOCK_TIMEOUT  = 65535;
  localparam logic [2:0] DEF_SEL           = SEL_PLL_OUT2;

  function automatic logic is_pll_sel(input logic [2:0] sel);
    return (sel >= SEL_PLL_OUT2) && (sel <= SEL_PLL_OUT5);
  endfunction

  // Select 0 is not a real source; it aliases the first PLL output.
  function automatic logic [2:0] norm_sel(input logic [2:0] sel);
    return (sel == 3'd0) ? SEL_PLL_OUT2 : sel;
  endfunction

  function automatic int cycles_of(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_switch_seq_timer.sv
// seq_timer: loadable down-counter that holds at zero; zero_o flags expiry.
// Load takes priority over counting; one cycle from load to new value.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_switch_seq.sv
// Glitch-free audio clock-source switch: mute, gate, reselect, settle/lock, ungate, unmute.
// Latency: MUTE+2*GATE+SETTLE+1 cycles per change; same-source request answers with done next cycle.
// Backpressure: req_ready only in IDLE, requests while busy are dropped; CLK_SWITCH_SEQ_LOCK_TIMEOUT_EN adds a PLL-lock timeout.
module clk_switch_seq
  import clk_pkg::*;
#(
  parameter int         MUTE_CYCLES   = DEF_MUTE_CYCLES,
  parameter int         GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int         LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter logic [2:0] DEFAULT_SEL   = DEF_SEL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_sel,
  output logic       req_ready,
  input  logic       pll_locked,
  output logic [2:0] clk_sel,
  output logic       clk_en,
  output logic       mute,
  output logic       busy,
  output logic       done,
  output logic       lock_err
);

  localparam int CW = $clog2(max_of(max_of(MUTE_CYCLES, GATE_CYCLES),
                                    max_of(SETTLE_CYCLES, LOCK_TIMEOUT))) + 1;

  localparam logic [CW-1:0] MUTE_LD   = CW'(cycles_of(MUTE_CYCLES) - 1);
  localparam logic [CW-1:0] GATE_LD   = CW'(cycles_of(GATE_CYCLES) - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(cycles_of(SETTLE_CYCLES) - 1);
  localparam logic [2:0]    RST_SEL   = norm_sel(DEFAULT_SEL);

  state_t     state_q, state_d;
  logic [2:0] clk_sel_q, clk_sel_d;
  logic [2:0] tgt_q, tgt_d;
  logic       clk_en_q, clk_en_d;
  logic       mute_q, mute_d;
  logic       done_q, done_d;
  logic       init_q;

  logic          accept;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_zero;
  logic          lock_to;

  assign req_ready = (state_q == IDLE);
  assign busy      = !req_ready;
  assign accept    = req_valid && req_ready;

  seq_timer #(.W(CW)) u_tmr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    clk_sel_d = clk_sel_q;
    tgt_d     = tgt_q;
    clk_en_d  = clk_en_q;
    mute_d    = mute_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    // Reset clears the counter, so the first cycle afterwards loads the startup settle time.
    if (init_q) begin
      tmr_load = 1'b1;
      tmr_val  = SETTLE_LD;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            tgt_d = norm_sel(req_sel);
            if (norm_sel(req_sel) == clk_sel_q) begin
              done_d = 1'b1;
            end else begin
              state_d  = MUTE;
              mute_d   = 1'b1;
              tmr_load = 1'b1;
              tmr_val  = MUTE_LD;
            end
          end
        end
        MUTE: begin
          if (tmr_zero) begin
            state_d  = GATE_PRE;
            clk_en_d = 1'b0;
            tmr_load = 1'b1;
            tmr_val  = GATE_LD;
          end
        end
        GATE_PRE: begin
          if (tmr_zero) begin
            state_d   = SETTLE;
            clk_sel_d = tgt_q;
            tmr_load  = 1'b1;
            tmr_val   = SETTLE_LD;
          end
        end
        SETTLE: begin
          if (tmr_zero && (!is_pll_sel(clk_sel_q) || pll_locked || lock_to)) begin
            // Only reachable unlocked via the lock timeout: fall back to the sub clock.
            if (is_pll_sel(clk_sel_q) && !pll_locked) begin
              clk_sel_d = SEL_SUB_OUT1;
            end
            state_d  = GATE_POST;
            tmr_load = 1'b1;
            tmr_val  = GATE_LD;
          end
        end
        GATE_POST: begin
          if (tmr_zero) begin
            state_d  = UNMUTE;
            clk_en_d = 1'b1;
          end
        end
        UNMUTE: begin
          state_d = IDLE;
          mute_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SETTLE;
      clk_sel_q <= RST_SEL;
      tgt_q     <= RST_SEL;
      clk_en_q  <= 1'b0;
      mute_q    <= 1'b1;
      done_q    <= 1'b0;
      init_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_sel_q <= clk_sel_d;
      tgt_q     <= tgt_d;
      clk_en_q  <= clk_en_d;
      mute_q    <= mute_d;
      done_q    <= done_d;
      init_q    <= 1'b0;
    end
  end

`ifdef CLK_SWITCH_SEQ_LOCK_TIMEOUT_EN
  localparam logic [CW-1:0] LOCK_LD = CW'(cycles_of(LOCK_TIMEOUT) - 1);

  logic lock_err_q;

  seq_timer #(.W(CW)) u_lock_tmr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load && (state_d == SETTLE)),
    .load_val_i(LOCK_LD),
    .zero_o    (lock_to)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_err_q <= 1'b0;
    end else if (accept) begin
      lock_err_q <= 1'b0;
    end else if ((state_q == SETTLE) && (state_d == GATE_POST) &&
                 is_pll_sel(clk_sel_q) && !pll_locked) begin
      lock_err_q <= 1'b1;
    end
  end

  assign lock_err = lock_err_q;
`else
  assign lock_to  = 1'b0;
  assign lock_err = 1'b0;
`endif

  assign clk_sel = clk_sel_q;
  assign clk_en  = clk_en_q;
  assign mute    = mute_q;
  assign done    = done_q;

endmodule

// File: tb/tb_clk_switch_seq.sv
// Scoreboarded bench for clk_switch_seq: expected output snapshots are queued per
// cycle when a request or reset is driven, then compared on the falling edge.
module tb_clk_switch_seq;

  localparam int M = 256;
  localparam int G = 16;
  localparam int S = 64;
`ifdef CLK_SWITCH_SEQ_LOCK_TIMEOUT_EN
  localparam int LT = 100;
`else
  localparam int LT = 65535;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_sel = 3'd0;
  logic       pll_locked = 1'b1;
  logic       req_ready, clk_en, mute, busy, done, lock_err;
  logic [2:0] clk_sel;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  clk_switch_seq #(.LOCK_TIMEOUT(LT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .pll_locked(pll_locked),
    .clk_sel   (clk_sel),
    .clk_en    (clk_en),
    .mute      (mute),
    .busy      (busy),
    .done      (done),
    .lock_err  (lock_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      tag;
    logic [8:0] exp;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, want);
    end
  endtask

  function automatic logic [8:0] snap();
    return {lock_err, req_ready, busy, done, mute, clk_en, clk_sel};
  endfunction

  function automatic logic [8:0] mk(input logic lerr, input logic bsy, input logic dn,
                                    input logic mt, input logic en, input logic [2:0] sel);
    return {lerr, ~bsy, bsy, dn, mt, en, sel};
  endfunction

  task automatic push(input int c, input string tag, input logic [8:0] e);
    exp_t it;
    it.cyc = c;
    it.tag = tag;
    it.exp = e;
    sbq.push_back(it);
  endtask

  logic       mon_on = 1'b0;
  logic [2:0] prev_sel;
  logic       prev_en;

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      if (mon_e.cyc < cyc) check_val({mon_e.tag, "_missed"}, cyc, mon_e.cyc);
      else                 check_val(mon_e.tag, {23'd0, snap()}, {23'd0, mon_e.exp});
    end
    // Select may only move while the gate was already closed and audio is muted.
    if (mon_on && clk_sel !== prev_sel)
      check_val("sel_chg_gated", {29'd0, prev_en, clk_en, mute}, 32'd1);
    prev_sel = clk_sel;
    prev_en  = clk_en;
  end

  task automatic push_startup(input int r);
    push(r + 1,         "rst_state",    mk(0, 1, 0, 1, 0, 3'd1));
    push(r + S + G,     "start_gated",  mk(0, 1, 0, 1, 0, 3'd1));
    push(r + S + G + 1, "start_ungate", mk(0, 1, 0, 1, 1, 3'd1));
    push(r + S + G + 2, "start_unmute", mk(0, 0, 1, 0, 1, 3'd1));
    push(r + S + G + 3, "start_idle",   mk(0, 0, 0, 0, 1, 3'd1));
  endtask

  task automatic push_seq(input int a, input logic [2:0] from, input logic [2:0] to,
                          input int settle_len, input logic [2:0] fin, input logic lerr);
    int e, x;
    e = a + M + G;
    x = e + settle_len;
    push(a,             "acc",          mk(0, 1, 0, 1, 1, from));
    push(a + M - 1,     "mute_en",      mk(0, 1, 0, 1, 1, from));
    push(a + M,         "gate_pre",     mk(0, 1, 0, 1, 0, from));
    push(e - 1,         "pre_sel_hold", mk(0, 1, 0, 1, 0, from));
    push(e,             "sel_new",      mk(0, 1, 0, 1, 0, to));
    push(x - 1,         "settle_end",   mk(0, 1, 0, 1, 0, to));
    push(x,             "gate_post",    mk(lerr, 1, 0, 1, 0, fin));
    push(x + G - 1,     "post_hold",    mk(lerr, 1, 0, 1, 0, fin));
    push(x + G,         "ungate",       mk(lerr, 1, 0, 1, 1, fin));
    push(x + G + 1,     "unmute_done",  mk(lerr, 0, 1, 0, 1, fin));
    push(x + G + 2,     "seq_idle",     mk(lerr, 0, 0, 0, 1, fin));
  endtask

  // Called on a falling edge; returns the cycle at which the request is accepted.
  task automatic start_req(input logic [2:0] s, output int a);
    int t;
    t = 0;
    while (!req_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_val("rdy_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_sel   = s;
    a = cyc + 1;
  endtask

  task automatic end_req();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sbq.size() > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check_val("drain", sbq.size(), 32'd0);
    sbq.delete();
  endtask

  initial begin
    int r, a, e, xg;
    logic [2:0] cur;

    repeat (3) @(posedge clk);
    @(negedge clk);
    r = cyc;
    rst = 1'b0;
    check_val("rst_outs", {23'd0, snap()}, {23'd0, mk(0, 1, 0, 1, 0, 3'd1)});
    push_startup(r);
    mon_on = 1'b1;
    wait_drain();

    // Same-source requests, including the 0 alias.
    start_req(3'd1, a);
    push(a,     "same1_done", mk(0, 0, 1, 0, 1, 3'd1));
    push(a + 1, "same1_clr",  mk(0, 0, 0, 0, 1, 3'd1));
    end_req();
    wait_drain();

    start_req(3'd0, a);
    push(a,     "same0_done", mk(0, 0, 1, 0, 1, 3'd1));
    push(a + 1, "same0_clr",  mk(0, 0, 0, 0, 1, 3'd1));
    end_req();
    wait_drain();

    // Sub-clock target with PLL unlocked: lock is ignored.
    pll_locked = 1'b0;
    start_req(3'd6, a);
    push_seq(a, 3'd1, 3'd6, S, 3'd6, 1'b0);
    end_req();
    wait_drain();

    start_req(3'd6, a);
    push(a,     "same6_done", mk(0, 0, 1, 0, 1, 3'd6));
    push(a + 1, "same6_clr",  mk(0, 0, 0, 0, 1, 3'd6));
    end_req();
    wait_drain();

    // PLL target with lock arriving ~500 cycles into SETTLE.
    start_req(3'd3, a);
    e = a + M + G;
`ifdef CLK_SWITCH_SEQ_LOCK_TIMEOUT_EN
    push_seq(a, 3'd6, 3'd3, LT, 3'd5, 1'b1);
    cur = 3'd5;
`else
    push_seq(a, 3'd6, 3'd3, 500, 3'd3, 1'b0);
    cur = 3'd3;
`endif
    end_req();
    while (cyc < e + 499) @(negedge clk);
    pll_locked = 1'b1;
    wait_drain();

    // req_valid held with changing req_sel through a whole sequence.
    start_req(3'd7, a);
    push_seq(a, cur, 3'd7, S, 3'd7, 1'b0);
    xg = a + M + G + S + G;
    for (int c = a; c <= xg; c++) begin
      @(negedge clk);
      req_sel = 3'(c % 7);
      check_val("rdy_busy", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    wait_drain();

    // Reset while in GATE_PRE.
    start_req(3'd2, a);
    push(a,     "acc2", mk(0, 1, 0, 1, 1, 3'd7));
    push(a + M, "gp2",  mk(0, 1, 0, 1, 0, 3'd7));
    end_req();
    while (cyc < a + M + 4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    r = cyc;
    rst = 1'b0;
    check_val("rst_mid", {23'd0, snap()}, {23'd0, mk(0, 1, 0, 1, 0, 3'd1)});
    push_startup(r);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: cyc %0d, required finish before 100000", cyc);
    $fatal(1, "watchdog");
  end

endmodule
